// File: rtl/debug_pkg.sv
// Shared definitions for the debug FSM family: command bytes, state encodings, count width.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package debug_pkg;

  // UART command bytes understood by the debug unit
  localparam logic [7:0] DBG_CMD_LOAD     = 8'h01;
  localparam logic [7:0] DBG_CMD_FAST     = 8'h02;
  localparam logic [7:0] DBG_CMD_STEP_MOD = 8'h03;
  localparam logic [7:0] DBG_CMD_STEP     = 8'h04;
  localparam logic [7:0] DBG_CMD_EXIT     = 8'h05;

  // Width of the clk_count field carried in the send frame
  localparam int DBG_CLK_COUNT_W = 32;

  // Top-level debug FSM states
  typedef enum logic [2:0] {
    DBG_IDLE,
    DBG_LOAD,
    DBG_FAST,
    DBG_STEP,
    DBG_WAIT_STEP,
    DBG_SEND
  } dbg_state_t;

  // Step-mode controller states
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START_SEND,
    ST_WAIT_SEND,
    ST_WAIT_CMD,
    ST_STEP,
    ST_DONE
  } step_state_t;

endpackage

// File: rtl/fsm_step_ctrl.sv
// Step-mode controller: one pipeline clock per UART step command, full dump after each step.
// Latency: rx strobe -> os_step next cycle; os_start_send one cycle after os_step; send_done -> os_done next cycle.
// Backpressure: none; rx/start/send_done strobes arriving in the wrong state are dropped, not buffered.
module fsm_step_ctrl
  import debug_pkg::*;
#(
  parameter logic [7:0] CMD_STEP      = DBG_CMD_STEP,
  parameter logic [7:0] CMD_EXIT      = DBG_CMD_EXIT,
  parameter int         CNT_W         = DBG_CLK_COUNT_W,
  parameter bit         SEND_ON_START = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             is_start,
  input  logic [7:0]       i_rx_data,
  input  logic             is_rx_done,
  input  logic             is_send_done,
  input  logic             is_stop_pipe,
  output logic             os_step,
  output logic             os_start_send,
  output logic             os_done,
  output logic [CNT_W-1:0] o_clk_count
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  step_state_t state;
  logic        stop_latch;

  // Single state register; every output is set on the edge that enters the
  // state it belongs to, so pulses line up exactly with their state cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      os_step       <= 1'b0;
      os_start_send <= 1'b0;
      os_done       <= 1'b0;
      o_clk_count   <= '0;
      stop_latch    <= 1'b0;
    end else begin
      os_step       <= 1'b0;
      os_start_send <= 1'b0;
      os_done       <= 1'b0;

      // Stop is sticky for the whole session; the IDLE branch clears it on start.
      if (state != ST_IDLE && is_stop_pipe) begin
        stop_latch <= 1'b1;
      end

      case (state)
        ST_IDLE: begin
          if (is_start) begin
            o_clk_count <= '0;
            stop_latch  <= 1'b0;
            if (SEND_ON_START) begin
              state         <= ST_START_SEND;
              os_start_send <= 1'b1;
            end else begin
              state <= ST_WAIT_CMD;
            end
          end
        end

        ST_WAIT_CMD: begin
          if (is_rx_done) begin
            if (i_rx_data == CMD_STEP) begin
              // Uses the latch value from before this cycle, so a stop that
              // coincides with the command still lets the step through.
              if (!stop_latch) begin
                state   <= ST_STEP;
                os_step <= 1'b1;
                if (o_clk_count != '1) begin
                  o_clk_count <= o_clk_count + CNT_ONE;
                end
              end else begin
                state   <= ST_DONE;
                os_done <= 1'b1;
              end
            end else if (i_rx_data == CMD_EXIT) begin
              state   <= ST_DONE;
              os_done <= 1'b1;
            end
          end
        end

        ST_STEP: begin
          // Dump one cycle after the step edge so pipe outputs have settled.
          state         <= ST_START_SEND;
          os_start_send <= 1'b1;
        end

        ST_START_SEND: begin
          state <= ST_WAIT_SEND;
        end

        ST_WAIT_SEND: begin
          if (is_send_done) begin
            if (stop_latch) begin
              state   <= ST_DONE;
              os_done <= 1'b1;
            end else begin
              state <= ST_WAIT_CMD;
            end
          end
        end

        ST_DONE: begin
          state <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
